// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32-bit register file with write bypass feeding a single-entry
// valid/ready register that drives the ALU operands; the held entry snoops writebacks.
module operand_fetch #(
  parameter int NREGS = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inValid,
  output logic          inReady,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rd,
  input  logic [1:0]    opIn,
  input  logic          wbEn,
  input  logic [AW-1:0] wbAddr,
  input  logic [31:0]   wbData,
  output logic          outValid,
  input  logic          outReady,
  output logic [31:0]   aluIn1,
  output logic [31:0]   aluIn2,
  output logic [1:0]    aluOp,
  output logic [AW-1:0] outRd
);

  logic [31:0]   r_regs [NREGS];
  logic          r_valid;
  logic [31:0]   r_in1;
  logic [31:0]   r_in2;
  logic [1:0]    r_op;
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_rs1;
  logic [AW-1:0] r_rs2;

  logic          w_wb_live;
  logic          w_accept;
  logic          w_snoop;
  logic [31:0]   w_op1;
  logic [31:0]   w_op2;

  // A writeback to r0 is treated as no writeback at all, for the file and the snoop.
  assign w_wb_live = wbEn && (wbAddr != '0);

  assign inReady  = !r_valid || outReady;
  assign w_accept = inValid && inReady;
  assign w_snoop  = r_valid && !w_accept && w_wb_live;

  always_comb begin
    w_op1 = '0;
    if (rs1 != '0) begin
      if (w_wb_live && (wbAddr == rs1)) w_op1 = wbData;
      else                              w_op1 = r_regs[rs1];
    end
  end

  always_comb begin
    w_op2 = '0;
    if (rs2 != '0) begin
      if (w_wb_live && (wbAddr == rs2)) w_op2 = wbData;
      else                              w_op2 = r_regs[rs2];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wb_live) begin
      r_regs[wbAddr] <= wbData;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_op    <= 2'b00;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_in1   <= w_op1;
      r_in2   <= w_op2;
      r_op    <= opIn;
      r_rd    <= rd;
      r_rs1   <= rs1;
      r_rs2   <= rs2;
    end else begin
      if (w_snoop && (r_rs1 == wbAddr)) r_in1 <= wbData;
      if (w_snoop && (r_rs2 == wbAddr)) r_in2 <= wbData;
      if (r_valid && outReady) r_valid <= 1'b0;
    end
  end

  assign outValid = r_valid;
  assign aluIn1   = r_in1;
  assign aluIn2   = r_in2;
  assign aluOp    = r_op;
  assign outRd    = r_rd;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized run
// against a behavioural model of the register file and held ALU entry.
module tb_operand_fetch;

  localparam int AW = 4;
  localparam int NR = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          inValid;
  logic          inReady;
  logic [AW-1:0] rs1, rs2, rd;
  logic [1:0]    opIn;
  logic          wbEn;
  logic [AW-1:0] wbAddr;
  logic [31:0]   wbData;
  logic          outValid;
  logic          outReady;
  logic [31:0]   aluIn1, aluIn2;
  logic [1:0]    aluOp;
  logic [AW-1:0] outRd;

  int n_pass = 0;
  int n_total = 0;

  // Model state: what the architectural registers hold and what the ALU should see.
  logic [31:0]   m_regs [NR];
  logic          m_valid;
  logic [31:0]   m_in1, m_in2;
  logic [1:0]    m_op;
  logic [AW-1:0] m_rd, m_rs1, m_rs2;

  operand_fetch #(.NREGS(NR), .AW(AW)) dut (
    .clk(clk), .reset(reset), .inValid(inValid), .inReady(inReady),
    .rs1(rs1), .rs2(rs2), .rd(rd), .opIn(opIn),
    .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
    .outValid(outValid), .outReady(outReady),
    .aluIn1(aluIn1), .aluIn2(aluIn2), .aluOp(aluOp), .outRd(outRd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_read(input logic [AW-1:0] idx);
    if (idx == 0) return 32'h0;
    if (wbEn && wbAddr == idx) return wbData;
    return m_regs[idx];
  endfunction

  task automatic m_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    m_valid = 1'b0; m_in1 = 0; m_in2 = 0; m_op = 0; m_rd = 0; m_rs1 = 0; m_rs2 = 0;
  endtask

  // Advance the model over one rising edge using the inputs currently applied.
  task automatic m_edge();
    logic acc;
    logic [31:0] o1, o2;
    if (reset) begin
      m_reset();
      return;
    end
    acc = inValid && (!m_valid || outReady);
    o1 = m_read(rs1);
    o2 = m_read(rs2);
    if (acc) begin
      m_valid = 1'b1; m_in1 = o1; m_in2 = o2; m_op = opIn; m_rd = rd;
      m_rs1 = rs1; m_rs2 = rs2;
    end else if (m_valid) begin
      if (wbEn && wbAddr != 0 && m_rs1 == wbAddr) m_in1 = wbData;
      if (wbEn && wbAddr != 0 && m_rs2 == wbAddr) m_in2 = wbData;
      if (outReady) m_valid = 1'b0;
    end
    if (wbEn && wbAddr != 0) m_regs[wbAddr] = wbData;
  endtask

  task automatic tick();
    m_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    inValid = 0; rs1 = 0; rs2 = 0; rd = 0; opIn = 0;
    wbEn = 0; wbAddr = 0; wbData = 0; outReady = 1;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
    idle();
    wbEn = 1; wbAddr = a; wbData = d;
    tick();
    idle();
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [AW-1:0] b,
                       input logic [1:0] op, input logic [AW-1:0] dst, input logic ordy);
    idle();
    inValid = 1; rs1 = a; rs2 = b; opIn = op; rd = dst; outReady = ordy;
    tick();
    idle();
    outReady = ordy;
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    m_reset();
    tick();
    tick();
    n_total++; if (inReady !== 1'b1) $display("FAIL reset_inReady_during got=%b exp=1", inReady); else n_pass++;
    reset = 0;
    #2;
    n_total++; if (outValid !== 1'b0) $display("FAIL reset_outValid got=%b exp=0", outValid); else n_pass++;
    n_total++; if (aluIn1 !== 32'h0) $display("FAIL reset_aluIn1 got=%h exp=0", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h0) $display("FAIL reset_aluIn2 got=%h exp=0", aluIn2); else n_pass++;
    n_total++; if (aluOp !== 2'b00) $display("FAIL reset_aluOp got=%b exp=00", aluOp); else n_pass++;
    n_total++; if (outRd !== 4'h0) $display("FAIL reset_outRd got=%h exp=0", outRd); else n_pass++;
    n_total++; if (inReady !== 1'b1) $display("FAIL reset_inReady_after got=%b exp=1", inReady); else n_pass++;
    @(posedge clk); #1;
  endtask

  task automatic test_first_issue();
    write_reg(3, 32'h10);
    write_reg(5, 32'h20);
    issue(3, 5, 2'b01, 4'd9, 1'b0);
    n_total++; if (outValid !== 1'b1) $display("FAIL first_valid got=%b exp=1", outValid); else n_pass++;
    n_total++; if (aluIn1 !== 32'h10) $display("FAIL first_in1 got=%h exp=10", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h20) $display("FAIL first_in2 got=%h exp=20", aluIn2); else n_pass++;
    n_total++; if (aluOp !== 2'b01) $display("FAIL first_op got=%b exp=01", aluOp); else n_pass++;
    n_total++; if (outRd !== 4'd9) $display("FAIL first_rd got=%h exp=9", outRd); else n_pass++;
    idle();
    tick();
    n_total++; if (outValid !== 1'b0) $display("FAIL first_consume got=%b exp=0", outValid); else n_pass++;
  endtask

  task automatic test_r0();
    write_reg(0, 32'hFFFF);
    issue(0, 0, 2'b10, 4'd1, 1'b1);
    n_total++; if (aluIn1 !== 32'h0) $display("FAIL r0_in1 got=%h exp=0", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h0) $display("FAIL r0_in2 got=%h exp=0", aluIn2); else n_pass++;
    // Writeback to r0 in the same cycle as a read of r0 must not bypass.
    idle();
    inValid = 1; rs1 = 0; rs2 = 3; wbEn = 1; wbAddr = 0; wbData = 32'hDEAD;
    tick();
    n_total++; if (aluIn1 !== 32'h0) $display("FAIL r0_bypass_in1 got=%h exp=0", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h10) $display("FAIL r0_bypass_in2 got=%h exp=10", aluIn2); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_bypass();
    write_reg(7, 32'h1);
    idle();
    inValid = 1; rs1 = 7; rs2 = 5; opIn = 2'b11; rd = 4'd2;
    wbEn = 1; wbAddr = 7; wbData = 32'hABCD;
    tick();
    n_total++; if (aluIn1 !== 32'hABCD) $display("FAIL bypass_in1 got=%h exp=abcd", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h20) $display("FAIL bypass_in2 got=%h exp=20", aluIn2); else n_pass++;
    issue(5, 7, 2'b00, 4'd3, 1'b1);
    n_total++; if (aluIn2 !== 32'hABCD) $display("FAIL bypass_persist got=%h exp=abcd", aluIn2); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_stall_snoop();
    write_reg(4, 32'h5);
    issue(3, 4, 2'b10, 4'd11, 1'b0);
    n_total++; if (aluIn2 !== 32'h5) $display("FAIL stall_pre_in2 got=%h exp=5", aluIn2); else n_pass++;
    idle();
    outReady = 0;
    inValid = 1; rs1 = 5; rs2 = 5; opIn = 2'b01; rd = 4'd6;
    wbEn = 1; wbAddr = 4; wbData = 32'h99;
    #1;
    n_total++; if (inReady !== 1'b0) $display("FAIL stall_inReady got=%b exp=0", inReady); else n_pass++;
    tick();
    n_total++; if (aluIn2 !== 32'h99) $display("FAIL snoop_in2 got=%h exp=99", aluIn2); else n_pass++;
    n_total++; if (aluIn1 !== 32'h10) $display("FAIL snoop_in1_kept got=%h exp=10", aluIn1); else n_pass++;
    n_total++; if (aluOp !== 2'b10) $display("FAIL stall_op got=%b exp=10", aluOp); else n_pass++;
    n_total++; if (outRd !== 4'd11) $display("FAIL stall_rd got=%h exp=b", outRd); else n_pass++;
    n_total++; if (outValid !== 1'b1) $display("FAIL stall_valid got=%b exp=1", outValid); else n_pass++;
    idle();
    tick();
    // Both held sources match one writeback.
    issue(8, 8, 2'b00, 4'd12, 1'b0);
    idle();
    outReady = 0; wbEn = 1; wbAddr = 8; wbData = 32'h1234_5678;
    tick();
    n_total++; if (aluIn1 !== 32'h1234_5678) $display("FAIL snoop_both_in1 got=%h exp=12345678", aluIn1); else n_pass++;
    n_total++; if (aluIn2 !== 32'h1234_5678) $display("FAIL snoop_both_in2 got=%h exp=12345678", aluIn2); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] dsts [3];
    dsts[0] = 4'd13; dsts[1] = 4'd14; dsts[2] = 4'd15;
    idle();
    for (int i = 0; i < 3; i++) begin
      inValid = 1; rs1 = 3; rs2 = 4'(i + 4); opIn = 2'(i); rd = dsts[i]; outReady = 1;
      tick();
      n_total++; if (outValid !== 1'b1) $display("FAIL b2b_valid%0d got=%b exp=1", i, outValid); else n_pass++;
      n_total++; if (outRd !== dsts[i]) $display("FAIL b2b_rd%0d got=%h exp=%h", i, outRd, dsts[i]); else n_pass++;
    end
    idle();
    tick();
    n_total++; if (outValid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", outValid); else n_pass++;
  endtask

  task automatic test_reset_mid_stall();
    write_reg(3, 32'h77);
    issue(3, 3, 2'b11, 4'd5, 1'b0);
    n_total++; if (outValid !== 1'b1) $display("FAIL rst_stall_held got=%b exp=1", outValid); else n_pass++;
    #2;
    reset = 1;
    m_reset();
    #1;
    n_total++; if (outValid !== 1'b0) $display("FAIL rst_async_valid got=%b exp=0", outValid); else n_pass++;
    n_total++; if (aluIn1 !== 32'h0) $display("FAIL rst_async_in1 got=%h exp=0", aluIn1); else n_pass++;
    // A writeback presented while reset is held must be dropped.
    wbEn = 1; wbAddr = 3; wbData = 32'h55;
    tick();
    idle();
    #1;
    reset = 0;
    issue(3, 0, 2'b00, 4'd1, 1'b1);
    n_total++; if (aluIn1 !== 32'h0) $display("FAIL rst_r3_cleared got=%h exp=0", aluIn1); else n_pass++;
    idle();
    tick();
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int c = 0; c < 400; c++) begin
      inValid  = 1'($urandom_range(0, 1));
      outReady = ($urandom_range(0, 3) != 0);
      rs1      = 4'($urandom_range(0, 15));
      rs2      = ($urandom_range(0, 3) == 0) ? rs1 : 4'($urandom_range(0, 15));
      rd       = 4'($urandom_range(0, 15));
      opIn     = 2'($urandom_range(0, 3));
      wbEn     = 1'($urandom_range(0, 1));
      wbAddr   = ($urandom_range(0, 1) == 0) ? rs1 : 4'($urandom_range(0, 15));
      wbData   = $urandom;
      #1;
      n_total++;
      if (inReady !== (!m_valid || outReady)) begin
        $display("FAIL rand_inReady cyc=%0d got=%b exp=%b", c, inReady, (!m_valid || outReady));
        errs++;
      end else n_pass++;
      tick();
      n_total++;
      if ({outValid, aluIn1, aluIn2, aluOp, outRd} !== {m_valid, m_in1, m_in2, m_op, m_rd}) begin
        if (errs < 10)
          $display("FAIL rand_out cyc=%0d got v=%b a=%h b=%h op=%b rd=%h exp v=%b a=%h b=%h op=%b rd=%h",
                   c, outValid, aluIn1, aluIn2, aluOp, outRd, m_valid, m_in1, m_in2, m_op, m_rd);
        errs++;
      end else n_pass++;
    end
    idle();
    tick();
  endtask

  initial begin
    idle();
    reset = 1;
    m_reset();
    test_reset();
    test_first_issue();
    test_r0();
    test_bypass();
    test_stall_snoop();
    test_back_to_back();
    test_reset_mid_stall();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
